oled_power_seq: RTL

Parametrised power sequencer for the PmodOLEDrgb (SSD1331) panel, replacing the fixed power-on-only sequencer. Drives the panel control pins (dc_c, res, vcc_en, pmod_en) through a full power-on sequence, including VCC enable, and a power-off sequence. Power-off includes a display-off command handshake with the SPI command engine, and a power-off request can abort a power-on in progress. Sits between the top-level OLED controller FSM and the pin drivers, next to the SPI command engine.

---
 rtl/oled_power_seq.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/oled_power_seq.sv
// ---------------------------------------------------------------------------
// oled_power_seq
//
// Power sequencer for the PmodOLEDrgb (SSD1331) panel. It drives the panel
// control pins through a full power-on sequence (logic supply, reset pulse,
// VCC enable) and a power-off sequence. Power-off asks the SPI command engine
// to send display-off (0xAE) before VCC is removed. A power-off request during
// power-on aborts the sequence and goes straight to VCC discharge.
//
// Ports:
//   sclk           in   system clock, all logic on posedge
//   rst            in   asynchronous active-high reset
//   power_on_req   in   level, sampled only in OFF
//   power_off_req  in   level, sampled in ON and in the power-on states
//   disp_off_ack   in   command engine has sent display-off
//   disp_off_req   out  request to command engine to send display-off
//   busy           out  high in every state except OFF and ON
//   powered        out  high only in ON
//   on_done        out  one-cycle pulse on entry to ON
//   off_done       out  one-cycle pulse on entry to OFF (not after reset)
//   dc_c           out  data/command select, held 0
//   res            out  panel reset, active low
//   vcc_en         out  panel VCC (13 V) enable
//   pmod_en        out  panel VDD logic enable
//
// Build option:
//   OLED_POWER_SEQ_FAST_SIM_EN  when defined, every wait is forced to 2 us
//                               (simulation only).
// ---------------------------------------------------------------------------
module oled_power_seq #(
    parameter int unsigned CLOCK_FREQUENCY_HZ   = 200000000,
    parameter int unsigned TIMER_W              = 32,
    parameter int unsigned WAIT_POWER_STABLE_US = 20000,
    parameter int unsigned WAIT_RESET_US        = 3,
    parameter int unsigned WAIT_VCC_ON_US       = 25000,
    parameter int unsigned WAIT_VCC_OFF_US      = 100000
) (
    input  logic sclk,
    input  logic rst,
    input  logic power_on_req,
    input  logic power_off_req,
    input  logic disp_off_ack,
    output logic disp_off_req,
    output logic busy,
    output logic powered,
    output logic on_done,
    output logic off_done,
    output logic dc_c,
    output logic res,
    output logic vcc_en,
    output logic pmod_en
);

    localparam int unsigned PRESCALE = CLOCK_FREQUENCY_HZ / 1000000;

`ifdef OLED_POWER_SEQ_FAST_SIM_EN
    localparam int unsigned W_STABLE  = 2;
    localparam int unsigned W_RESET   = 2;
    localparam int unsigned W_VCC_ON  = 2;
    localparam int unsigned W_VCC_OFF = 2;
`else
    localparam int unsigned W_STABLE  = WAIT_POWER_STABLE_US;
    localparam int unsigned W_RESET   = WAIT_RESET_US;
    localparam int unsigned W_VCC_ON  = WAIT_VCC_ON_US;
    localparam int unsigned W_VCC_OFF = WAIT_VCC_OFF_US;
`endif

    localparam longint unsigned MAX_A    = (W_STABLE > W_RESET) ? W_STABLE : W_RESET;
    localparam longint unsigned MAX_B    = (W_VCC_ON > W_VCC_OFF) ? W_VCC_ON : W_VCC_OFF;
    localparam longint unsigned MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam longint unsigned MIN_A    = (W_STABLE < W_RESET) ? W_STABLE : W_RESET;
    localparam longint unsigned MIN_B    = (W_VCC_ON < W_VCC_OFF) ? W_VCC_ON : W_VCC_OFF;
    localparam longint unsigned MIN_WAIT = (MIN_A < MIN_B) ? MIN_A : MIN_B;
    localparam longint unsigned TIMER_MAX = (TIMER_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                            : ((64'd1 << TIMER_W) - 64'd1);

    if (PRESCALE < 1) begin : g_chk_prescale
        $error("oled_power_seq: CLOCK_FREQUENCY_HZ must give at least 1 cycle per us");
    end
    if (MIN_WAIT < 1) begin : g_chk_min_wait
        $error("oled_power_seq: every wait must be at least 1 us");
    end
    if (MAX_WAIT * PRESCALE > TIMER_MAX) begin : g_chk_timer_w
        $error("oled_power_seq: longest wait in cycles does not fit in TIMER_W");
    end

    // Counters are loaded with (value - 1) so that a state entered at edge E
    // leaves on edge E + N*PRESCALE, i.e. it is active for exactly N*PRESCALE cycles.
    localparam logic [TIMER_W-1:0] PRE_LOAD   = TIMER_W'(PRESCALE - 1);
    localparam logic [TIMER_W-1:0] LD_STABLE  = TIMER_W'(W_STABLE - 1);
    localparam logic [TIMER_W-1:0] LD_RESET   = TIMER_W'(W_RESET - 1);
    localparam logic [TIMER_W-1:0] LD_VCC_ON  = TIMER_W'(W_VCC_ON - 1);
    localparam logic [TIMER_W-1:0] LD_VCC_OFF = TIMER_W'(W_VCC_OFF - 1);
    localparam logic [TIMER_W-1:0] ONE        = TIMER_W'(1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PON_STABLE,
        ST_PON_RESET,
        ST_PON_RECOVER,
        ST_PON_VCC,
        ST_ON,
        ST_POFF_CMD,
        ST_POFF_VCC
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] pre_q, pre_d;
    logic [TIMER_W-1:0] us_q, us_d;
    logic               disp_off_req_q, disp_off_req_d;
    logic               busy_q, busy_d;
    logic               powered_q, powered_d;
    logic               on_done_q, on_done_d;
    logic               off_done_q, off_done_d;
    logic               dc_c_q, dc_c_d;
    logic               res_q, res_d;
    logic               vcc_en_q, vcc_en_d;
    logic               pmod_en_q, pmod_en_d;
    logic               timer_done;
    logic               in_pon;

    assign timer_done = (pre_q == '0) && (us_q == '0);
    assign in_pon     = (state_q == ST_PON_STABLE) || (state_q == ST_PON_RESET) ||
                        (state_q == ST_PON_RECOVER) || (state_q == ST_PON_VCC);

    always_comb begin
        state_d        = state_q;
        disp_off_req_d = disp_off_req_q;
        res_d          = res_q;
        vcc_en_d       = vcc_en_q;
        pmod_en_d      = pmod_en_q;
        dc_c_d         = 1'b0;
        on_done_d      = 1'b0;
        off_done_d     = 1'b0;

        // Free-running count-down; overridden below when a timed state is entered.
        pre_d = pre_q;
        us_d  = us_q;
        if (pre_q != '0) begin
            pre_d = pre_q - ONE;
        end else if (us_q != '0) begin
            us_d  = us_q - ONE;
            pre_d = PRE_LOAD;
        end

        case (state_q)
            ST_OFF: begin
                if (power_on_req && !power_off_req) begin
                    state_d   = ST_PON_STABLE;
                    pmod_en_d = 1'b1;
                    res_d     = 1'b1;
                    pre_d     = PRE_LOAD;
                    us_d      = LD_STABLE;
                end
            end
            ST_ON: begin
                if (power_off_req) begin
                    state_d        = ST_POFF_CMD;
                    disp_off_req_d = 1'b1;
                end
            end
            ST_POFF_CMD: begin
                if (disp_off_ack) begin
                    state_d        = ST_POFF_VCC;
                    disp_off_req_d = 1'b0;
                    vcc_en_d       = 1'b0;
                    pre_d          = PRE_LOAD;
                    us_d           = LD_VCC_OFF;
                end
            end
            ST_POFF_VCC: begin
                if (timer_done) begin
                    state_d    = ST_OFF;
                    pmod_en_d  = 1'b0;
                    res_d      = 1'b0;
                    off_done_d = 1'b1;
                end
            end
            default: begin
                // Power-on states: abort has priority over timer expiry.
                if (in_pon && power_off_req) begin
                    state_d  = ST_POFF_VCC;
                    vcc_en_d = 1'b0;
                    res_d    = 1'b1;
                    pre_d    = PRE_LOAD;
                    us_d     = LD_VCC_OFF;
                end else if (timer_done) begin
                    case (state_q)
                        ST_PON_STABLE: begin
                            state_d = ST_PON_RESET;
                            res_d   = 1'b0;
                            pre_d   = PRE_LOAD;
                            us_d    = LD_RESET;
                        end
                        ST_PON_RESET: begin
                            state_d = ST_PON_RECOVER;
                            res_d   = 1'b1;
                            pre_d   = PRE_LOAD;
                            us_d    = LD_RESET;
                        end
                        ST_PON_RECOVER: begin
                            state_d  = ST_PON_VCC;
                            vcc_en_d = 1'b1;
                            pre_d    = PRE_LOAD;
                            us_d     = LD_VCC_ON;
                        end
                        ST_PON_VCC: begin
                            state_d   = ST_ON;
                            on_done_d = 1'b1;
                        end
                        default: begin
                            state_d = ST_OFF;
                        end
                    endcase
                end
            end
        endcase

        // Status outputs follow the next state so they change on the same edge.
        busy_d    = (state_d != ST_OFF) && (state_d != ST_ON);
        powered_d = (state_d == ST_ON);
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_OFF;
            pre_q          <= '0;
            us_q           <= '0;
            disp_off_req_q <= 1'b0;
            busy_q         <= 1'b0;
            powered_q      <= 1'b0;
            on_done_q      <= 1'b0;
            off_done_q     <= 1'b0;
            dc_c_q         <= 1'b0;
            res_q          <= 1'b0;
            vcc_en_q       <= 1'b0;
            pmod_en_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pre_q          <= pre_d;
            us_q           <= us_d;
            disp_off_req_q <= disp_off_req_d;
            busy_q         <= busy_d;
            powered_q      <= powered_d;
            on_done_q      <= on_done_d;
            off_done_q     <= off_done_d;
            dc_c_q         <= dc_c_d;
            res_q          <= res_d;
            vcc_en_q       <= vcc_en_d;
            pmod_en_q      <= pmod_en_d;
        end
    end

    assign disp_off_req = disp_off_req_q;
    assign busy         = busy_q;
    assign powered      = powered_q;
    assign on_done      = on_done_q;
    assign off_done     = off_done_q;
    assign dc_c         = dc_c_q;
    assign res          = res_q;
    assign vcc_en       = vcc_en_q;
    assign pmod_en      = pmod_en_q;

endmodule
